bilinear_scaler_param: RTL

Parametrised sequential bilinear/nearest image scaler engine, successor to the fixed 64x64 sequential DSA core. It takes runtime input/output dimensions and a Q-format inverse scale step, and fetches source pixels over a synchronous RAM read port. It writes interpolated pixels over a RAM write port and adds a nearest-neighbour mode, single-step debug mode and config error reporting. It sits between the input and output image memories inside the DSA top, replacing the fixed-size core.

---
 rtl/bilinear_scaler_param_pkg.sv | 21 ++
 rtl/bilinear_scaler_param_if.sv | 39 +++
 rtl/bilinear_scaler_param_lerp2d.sv | 44 ++++
 rtl/bilinear_scaler_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bilinear_scaler_param_pkg.sv
// Shared types and fixed-point constants for the parametrised bilinear/nearest scaler.
package bilinear_scaler_param_pkg;

  localparam int FRAC_W_DEF = 8;
  localparam int ONE        = 1 << FRAC_W_DEF;
  localparam int HALF       = ONE / 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_COORD,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_RDL,
    S_CALC,
    S_WRITE,
    S_STEP_WAIT
  } scaler_state_t;

endpackage

// File: rtl/bilinear_scaler_param_if.sv
// Control, config, source-read and destination-write signals of the scaler.
interface bilinear_scaler_param_if #(
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              mode;
  logic              step_en;
  logic              step;
  logic [DIM_W-1:0]  cfg_in_w;
  logic [DIM_W-1:0]  cfg_in_h;
  logic [DIM_W-1:0]  cfg_out_w;
  logic [DIM_W-1:0]  cfg_out_h;
  logic [15:0]       cfg_inv;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mode, step_en, step,
    output cfg_in_w, cfg_in_h, cfg_out_w, cfg_out_h, cfg_inv,
    output rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, mode, step_en, step,
    input  cfg_in_w, cfg_in_h, cfg_out_w, cfg_out_h, cfg_inv,
    input  rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/bilinear_scaler_param_lerp2d.sv
// Registered 2-D linear interpolation of four neighbours; rounds to nearest and saturates.
module bilinear_scaler_param_lerp2d
  import bilinear_scaler_param_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PIX_W-1:0]  p00,
  input  logic [PIX_W-1:0]  p01,
  input  logic [PIX_W-1:0]  p10,
  input  logic [PIX_W-1:0]  p11,
  input  logic [FRAC_W-1:0] fx,
  input  logic [FRAC_W-1:0] fy,
  output logic [PIX_W-1:0]  pix
);
  localparam int              ACC_W   = PIX_W + 2*FRAC_W + 2;
  localparam logic [FRAC_W:0] ONE_Q   = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [ACC_W-1:0] RND    = ACC_W'(1) << (2*FRAC_W - 1);
  localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'({PIX_W{1'b1}});

  logic [FRAC_W:0]  wx0, wx1, wy0, wy1;
  logic [ACC_W-1:0] top, bot, sum, quo;

  assign wx1 = {1'b0, fx};
  assign wx0 = ONE_Q - wx1;
  assign wy1 = {1'b0, fy};
  assign wy0 = ONE_Q - wy1;

  assign top = ACC_W'(p00) * ACC_W'(wx0) + ACC_W'(p01) * ACC_W'(wx1);
  assign bot = ACC_W'(p10) * ACC_W'(wx0) + ACC_W'(p11) * ACC_W'(wx1);
  assign sum = top * ACC_W'(wy0) + bot * ACC_W'(wy1) + RND;
  assign quo = sum >> (2*FRAC_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix <= '0;
    end else if (en) begin
      pix <= (quo > PIX_MAX) ? {PIX_W{1'b1}} : quo[PIX_W-1:0];
    end
  end
endmodule

// File: rtl/bilinear_scaler_param.sv
// Sequential image scaler: walks the output raster, fetches neighbours from source RAM, writes result.
//   state     | meaning
//   IDLE      | waiting for start; config checked on accept
//   COORD     | latch clamped integer/fraction source coordinates
//   RD0..RD3  | read p00, p01, p10, p11 (nearest: RD0 reads the chosen pixel only)
//   RDL       | capture last read datum
//   CALC      | bilinear datapath registers the output pixel
//   WRITE     | write pixel, advance raster position
//   STEP_WAIT | paused after a pixel until a step pulse
module bilinear_scaler_param
  import bilinear_scaler_param_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 16,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input logic clk,
  input logic rst,
  bilinear_scaler_param_if.slave bus
);
  // accumulators must hold out_dim * inv without wrapping
  localparam int ACC_W = DIM_W + 17;
  localparam int INT_W = ACC_W - FRAC_W;

  scaler_state_t state, state_nxt;

  logic              mode_q;
  logic [DIM_W-1:0]  in_w_q, in_h_q, out_w_q, out_h_q;
  logic [15:0]       inv_q;
  logic [DIM_W-1:0]  ox, oy;
  logic [ACC_W-1:0]  sx, sy;
  logic [DIM_W-1:0]  ix, x1, iy, y1;
  logic [FRAC_W-1:0] fx, fy;
  logic [PIX_W-1:0]  p00, p01, p10, p11;
  logic              done_q, err_q;

  logic [INT_W-1:0]  sx_int, sy_int;
  logic [DIM_W-1:0]  ix_c, x1_c, iy_c, y1_c;
  logic [FRAC_W-1:0] fx_c, fy_c;
  logic [DIM_W-1:0]  row_sel, col_sel;
  logic [ADDR_W-1:0] rd_lin, wr_lin;
  logic [PIX_W-1:0]  lerp_pix;
  logic              cfg_bad, row_end, last_pix;
  logic              rd_en, wr_en;

  assign cfg_bad = (bus.cfg_in_w == '0) || (bus.cfg_in_h == '0) ||
                   (bus.cfg_out_w == '0) || (bus.cfg_out_h == '0) ||
                   (bus.cfg_inv == '0);
  assign row_end  = (ox == out_w_q - 1'b1);
  assign last_pix = row_end && (oy == out_h_q - 1'b1);

  assign sx_int = sx[ACC_W-1:FRAC_W];
  assign sy_int = sy[ACC_W-1:FRAC_W];

  // Past the right/bottom edge the sample pins to the last column/row with zero weight.
  always_comb begin
    ix_c = sx_int[DIM_W-1:0];
    fx_c = sx[FRAC_W-1:0];
    if (sx_int >= {{(INT_W-DIM_W){1'b0}}, in_w_q}) begin
      ix_c = in_w_q - 1'b1;
      fx_c = '0;
    end
    x1_c = (ix_c == in_w_q - 1'b1) ? ix_c : ix_c + 1'b1;

    iy_c = sy_int[DIM_W-1:0];
    fy_c = sy[FRAC_W-1:0];
    if (sy_int >= {{(INT_W-DIM_W){1'b0}}, in_h_q}) begin
      iy_c = in_h_q - 1'b1;
      fy_c = '0;
    end
    y1_c = (iy_c == in_h_q - 1'b1) ? iy_c : iy_c + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.start && !cfg_bad) state_nxt = S_COORD;
      S_COORD:     state_nxt = S_RD0;
      S_RD0:       state_nxt = mode_q ? S_RDL : S_RD1;
      S_RD1:       state_nxt = S_RD2;
      S_RD2:       state_nxt = S_RD3;
      S_RD3:       state_nxt = S_RDL;
      S_RDL:       state_nxt = mode_q ? S_WRITE : S_CALC;
      S_CALC:      state_nxt = S_WRITE;
      S_WRITE: begin
        if (last_pix)         state_nxt = S_IDLE;
        else if (bus.step_en) state_nxt = S_STEP_WAIT;
        else                  state_nxt = S_COORD;
      end
      S_STEP_WAIT: if (bus.step) state_nxt = S_COORD;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Nearest picks the upper neighbour when the fraction is at least one half (MSB set).
  always_comb begin
    row_sel = iy;
    col_sel = ix;
    case (state)
      S_RD0: begin
        if (mode_q) begin
          row_sel = fy[FRAC_W-1] ? y1 : iy;
          col_sel = fx[FRAC_W-1] ? x1 : ix;
        end
      end
      S_RD1:   col_sel = x1;
      S_RD2:   row_sel = y1;
      S_RD3: begin
        row_sel = y1;
        col_sel = x1;
      end
      default: ;
    endcase
  end

  assign rd_lin = ADDR_W'(row_sel) * ADDR_W'(in_w_q) + ADDR_W'(col_sel);
  assign wr_lin = ADDR_W'(oy) * ADDR_W'(out_w_q) + ADDR_W'(ox);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      in_w_q  <= '0;
      in_h_q  <= '0;
      out_w_q <= '0;
      out_h_q <= '0;
      inv_q   <= '0;
      ox      <= '0;
      oy      <= '0;
      sx      <= '0;
      sy      <= '0;
      ix      <= '0;
      x1      <= '0;
      iy      <= '0;
      y1      <= '0;
      fx      <= '0;
      fy      <= '0;
      p00     <= '0;
      p01     <= '0;
      p10     <= '0;
      p11     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            done_q  <= cfg_bad;
            err_q   <= cfg_bad;
            mode_q  <= bus.mode;
            in_w_q  <= bus.cfg_in_w;
            in_h_q  <= bus.cfg_in_h;
            out_w_q <= bus.cfg_out_w;
            out_h_q <= bus.cfg_out_h;
            inv_q   <= bus.cfg_inv;
            ox      <= '0;
            oy      <= '0;
            sx      <= '0;
            sy      <= '0;
          end
        end
        S_COORD: begin
          ix <= ix_c;
          x1 <= x1_c;
          iy <= iy_c;
          y1 <= y1_c;
          fx <= fx_c;
          fy <= fy_c;
        end
        S_RD1: p00 <= bus.rd_data;
        S_RD2: p01 <= bus.rd_data;
        S_RD3: p10 <= bus.rd_data;
        // in nearest mode p11 holds the single fetched pixel
        S_RDL: p11 <= bus.rd_data;
        S_WRITE: begin
          if (last_pix) begin
            done_q <= 1'b1;
          end else if (row_end) begin
            ox <= '0;
            sx <= '0;
            oy <= oy + 1'b1;
            sy <= sy + ACC_W'(inv_q);
          end else begin
            ox <= ox + 1'b1;
            sx <= sx + ACC_W'(inv_q);
          end
        end
        default: ;
      endcase
    end
  end

  bilinear_scaler_param_lerp2d #(
    .PIX_W (PIX_W),
    .FRAC_W(FRAC_W)
  ) u_lerp (
    .clk(clk),
    .rst(rst),
    .en (state == S_CALC),
    .p00(p00),
    .p01(p01),
    .p10(p10),
    .p11(p11),
    .fx (fx),
    .fy (fy),
    .pix(lerp_pix)
  );

  assign rd_en = (state == S_RD0) || (state == S_RD1) ||
                 (state == S_RD2) || (state == S_RD3);
  assign wr_en = (state == S_WRITE);

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_en ? rd_lin : '0;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_en ? wr_lin : '0;
  assign bus.wr_data = wr_en ? (mode_q ? p11 : lerp_pix) : '0;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule
